// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing generator (640x480@60 by default).
// Divides clk into pixel slots, advances the horizontal/vertical counters
// once per slot and registers valid/hsync/vsync from the next counter values,
// so every output changes on the same edge as the counters.
// Optional feature macro: VGA_FRAME_TICK_EN adds a registered frame-start strobe;
// without it frame_tick is tied low.
module vga_sync_gen #(
  parameter int CLK_DIV = 4,
  parameter int H_DISP  = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_DISP  = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       valid,
  output logic       hsync,
  output logic       vsync,
  output logic       pix_tick,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [9:0]       H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [DIV_W-1:0] DIV_END = DIV_W'(CLK_DIV - 1);

  // Half-open window test lo <= c < hi on a counter value.
  function automatic logic in_win(input logic [9:0] c, input int lo, input int hi);
    return (int'(c) >= lo) && (int'(c) < hi);
  endfunction

  logic [DIV_W-1:0] div_cnt;
  logic             en_p0;
  logic [9:0]       h_nxt_p0;
  logic [9:0]       v_nxt_p0;
  logic             h_wrap_p0;

  assign en_p0 = (div_cnt == DIV_END);

  // Stage p0: clock divider producing the pixel-slot enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (en_p0) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Next counter values; equal to the current ones between slot edges.
  always_comb begin
    h_nxt_p0  = h_cnt;
    v_nxt_p0  = v_cnt;
    h_wrap_p0 = (h_cnt == H_LAST);
    if (en_p0) begin
      h_nxt_p0 = h_wrap_p0 ? 10'd0 : h_cnt + 10'd1;
      if (h_wrap_p0) begin
        v_nxt_p0 = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
      end
    end
  end

  // Stage p1: counters and their decodes loaded together, so outputs never skew.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt    <= H_LAST;
      v_cnt    <= V_LAST;
      valid    <= 1'b0;
      hsync    <= 1'b1;
      vsync    <= 1'b1;
      pix_tick <= 1'b0;
    end else begin
      h_cnt    <= h_nxt_p0;
      v_cnt    <= v_nxt_p0;
      valid    <= in_win(h_nxt_p0, 0, H_DISP) && in_win(v_nxt_p0, 0, V_DISP);
      hsync    <= ~in_win(h_nxt_p0, H_DISP + H_FP, H_DISP + H_FP + H_SYNC);
      vsync    <= ~in_win(v_nxt_p0, V_DISP + V_FP, V_DISP + V_FP + V_SYNC);
      pix_tick <= en_p0;
    end
  end

`ifdef VGA_FRAME_TICK_EN
  // Frame-start strobe: high with pix_tick when the counters land on (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= en_p0 && (h_nxt_p0 == 10'd0) && (v_nxt_p0 == 10'd0);
    end
  end
`else
  assign frame_tick = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: randomized-reset bench for vga_sync_gen. Three instances
// (default timing, CLK_DIV=1, and a tiny raster that wraps many frames) are
// compared every cycle against an arithmetic model of the raster position.
module tb_vga_sync_gen;

`ifdef VGA_FRAME_TICK_EN
  localparam bit FT_EN = 1'b1;
`else
  localparam bit FT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [9:0] h_a, v_a, h_b, v_b, h_c, v_c;
  logic vl_a, hs_a, vs_a, pt_a, ft_a;
  logic vl_b, hs_b, vs_b, pt_b, ft_b;
  logic vl_c, hs_c, vs_c, pt_c, ft_c;

  vga_sync_gen u_def (
    .clk(clk), .rst(rst), .h_cnt(h_a), .v_cnt(v_a), .valid(vl_a), .hsync(hs_a),
    .vsync(vs_a), .pix_tick(pt_a), .frame_tick(ft_a)
  );

  vga_sync_gen #(.CLK_DIV(1)) u_div1 (
    .clk(clk), .rst(rst), .h_cnt(h_b), .v_cnt(v_b), .valid(vl_b), .hsync(hs_b),
    .vsync(vs_b), .pix_tick(pt_b), .frame_tick(ft_b)
  );

  vga_sync_gen #(.CLK_DIV(2), .H_DISP(10), .H_FP(3), .H_SYNC(4), .H_BP(5),
                 .V_DISP(6), .V_FP(2), .V_SYNC(3), .V_BP(2)) u_small (
    .clk(clk), .rst(rst), .h_cnt(h_c), .v_cnt(v_c), .valid(vl_c), .hsync(hs_c),
    .vsync(vs_c), .pix_tick(pt_c), .frame_tick(ft_c)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Clock edges since reset release; zero while reset is held.
  int t = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) t <= 0;
    else     t <= t + 1;
  end

  // Reference: after t edges, n = t/cd pixel slots have elapsed. Reset parks the
  // raster on the last pixel, so the displayed pixel is slot (n-1) mod frame size.
  task automatic model_check(input string tag, input int cd,
                             input int hd, input int hfp, input int hs, input int hbp,
                             input int vd, input int vfp, input int vs, input int vbp,
                             input logic [9:0] h, input logic [9:0] v, input logic vl,
                             input logic hsy, input logic vsy, input logic pt, input logic ft);
    int ht, vt, tot, n, p, eh, ev;
    bit e_pt;
    ht  = hd + hfp + hs + hbp;
    vt  = vd + vfp + vs + vbp;
    tot = ht * vt;
    n   = t / cd;
    p   = (n + tot - 1) % tot;
    eh  = p % ht;
    ev  = p / ht;
    e_pt = (t > 0) && (t % cd == 0);
    check({tag, ".h_cnt"}, int'(h), eh);
    check({tag, ".v_cnt"}, int'(v), ev);
    check({tag, ".valid"}, int'(vl), int'(eh < hd && ev < vd));
    check({tag, ".hsync"}, int'(hsy), int'(!(eh >= hd + hfp && eh < hd + hfp + hs)));
    check({tag, ".vsync"}, int'(vsy), int'(!(ev >= vd + vfp && ev < vd + vfp + vs)));
    check({tag, ".pix_tick"}, int'(pt), int'(e_pt));
    check({tag, ".frame_tick"}, int'(ft), int'(FT_EN && e_pt && p == 0));
  endtask

  task automatic check_all();
    model_check("def",   4, 640, 16, 96, 48, 480, 10, 2, 33, h_a, v_a, vl_a, hs_a, vs_a, pt_a, ft_a);
    model_check("div1",  1, 640, 16, 96, 48, 480, 10, 2, 33, h_b, v_b, vl_b, hs_b, vs_b, pt_b, ft_b);
    model_check("small", 2, 10, 3, 4, 5, 6, 2, 3, 2, h_c, v_c, vl_c, hs_c, vs_c, pt_c, ft_c);
  endtask

  // hsync-low clocks within the first line after the initial release.
  bit first_run = 1'b1;
  int hs_low_def = 0;
  int hs_low_div1 = 0;

  always @(negedge clk) begin
    check_all();
    if (first_run && !rst) begin
      if (t >= 1 && t <= 3200 && !hs_a) hs_low_def++;
      if (t >= 1 && t <= 800 && !hs_b) hs_low_div1++;
    end
  end

  // Asynchronous reset in the middle of a clock phase, checked before any edge.
  task automatic mid_cycle_reset(input int hold);
    @(negedge clk);
    #($urandom_range(1, 3));
    rst = 1'b1;
    #1;
    check_all();
    repeat (hold) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10000) @(negedge clk);
    first_run = 1'b0;
    check("def.hsync_low_clks", hs_low_def, 384);
    check("div1.hsync_low_clks", hs_low_div1, 96);

    // Reset near h=300 of the default raster, then restart from power-up state.
    mid_cycle_reset(1);
    repeat (4 + 300 * 4) @(negedge clk);
    check("def.h_before_reset", int'(h_a), 300);
    mid_cycle_reset(2);

    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(200, 3000)) @(negedge clk);
      mid_cycle_reset($urandom_range(1, 3));
    end
    repeat (600) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
